// File: rtl/queue_unpacker_pkg.sv
// queue_unpacker_pkg: shared state encoding and reset constants for the queue unpacker
package queue_unpacker_pkg;
  typedef enum logic {
    QUEUE_UNPACKER_EMPTY = 1'b0,
    QUEUE_UNPACKER_BUSY  = 1'b1
  } queue_unpacker_state_t;
  localparam int QUEUE_UNPACKER_CNT_RST = 0;
endpackage

// File: rtl/queue_unpacker.sv
// queue_unpacker: pops wide queue entries and emits them as narrow valid/ready beats
// Define QUEUE_UNPACKER_MSB_FIRST_EN for MSB-first beat order (default LSB-first).
module queue_unpacker
  import queue_unpacker_pkg::*;
#(
  parameter int dbits = 128,
  parameter int obits = 32
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_q_nempty,
  input  logic [dbits-1:0] i_q_rdata,
  output logic             o_q_re,
  output logic             o_valid,
  output logic [obits-1:0] o_data,
  output logic             o_last,
  input  logic             i_ready
);
  localparam int RATIO = dbits / obits;
  localparam int CW = $clog2(RATIO + 1);
  typedef struct packed {
    queue_unpacker_state_t state;
    logic [CW-1:0]         cnt;
    logic [dbits-1:0]      data;
  } regs_t;
  regs_t r_q;
  regs_t w_d;
  logic w_hs;
  logic w_re;
  logic [dbits-1:0] w_shift;
`ifdef QUEUE_UNPACKER_MSB_FIRST_EN
  assign w_shift = r_q.data << obits;
  assign o_data = r_q.data[dbits-1 -: obits];
`else
  assign w_shift = r_q.data >> obits;
  assign o_data = r_q.data[obits-1:0];
`endif
  assign o_valid = r_q.state == QUEUE_UNPACKER_BUSY;
  assign o_last = r_q.cnt == CW'(1);
  assign o_q_re = w_re & i_nrst;
  // next state: pop when empty, shift on handshake, refill in place after the last beat
  always_comb begin
    w_hs = (r_q.state == QUEUE_UNPACKER_BUSY) & i_ready;
    w_d = r_q;
    w_re = 1'b0;
    if (r_q.state == QUEUE_UNPACKER_EMPTY) w_re = i_q_nempty;
    else if (w_hs && r_q.cnt > CW'(1)) begin
      w_d.data = w_shift;
      w_d.cnt = r_q.cnt - CW'(1);
    end else if (w_hs) begin
      w_re = i_q_nempty;
      w_d.cnt = CW'(QUEUE_UNPACKER_CNT_RST);
      w_d.state = QUEUE_UNPACKER_EMPTY;
    end
    if (w_re) begin
      w_d.data = i_q_rdata;
      w_d.cnt = CW'(RATIO);
      w_d.state = QUEUE_UNPACKER_BUSY;
    end
  end
  // register update; reset discards any partially sent entry
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) r_q <= '{state: QUEUE_UNPACKER_EMPTY, cnt: CW'(QUEUE_UNPACKER_CNT_RST), data: '0};
    else r_q <= w_d;
  end
endmodule
